// File: rtl/rs_kes_ibm_if.sv
// Handshake bundle between the syndrome stage, the key-equation solver and Chien/Forney.
interface rs_kes_ibm_if;
  logic       syndrome_val;
  logic [7:0] syndrome1, syndrome2, syndrome3, syndrome4;
  logic       busy;
  logic       key_val;
  logic [7:0] lambda0, lambda1, lambda2;
  logic [7:0] omega0, omega1;
  logic [2:0] err_deg;
  logic       uncorrectable;
  logic       overrun;

  modport master (
    output syndrome_val, syndrome1, syndrome2, syndrome3, syndrome4,
    input  busy, key_val, lambda0, lambda1, lambda2, omega0, omega1,
           err_deg, uncorrectable, overrun
  );

  modport slave (
    input  syndrome_val, syndrome1, syndrome2, syndrome3, syndrome4,
    output busy, key_val, lambda0, lambda1, lambda2, omega0, omega1,
           err_deg, uncorrectable, overrun
  );
endinterface

// File: rtl/rs_kes_ibm.sv
// Inversionless Berlekamp-Massey key-equation solver, RS(255,251), GF(256)/0x11D, t=2.
// Define RS_KES_ZERO_BYPASS_EN to short-circuit all-zero syndromes straight to OMEGA.

module gf256mul (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] acc, sh;

  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1d : 8'h00);
    end
  end

  assign p = acc;
endmodule

module rs_kes_ibm (
  input  logic        clk,
  input  logic        rst_n,
  rs_kes_ibm_if.slave kes
);
  typedef enum logic [1:0] {IDLE, DISC, UPD, OMEGA} state_t;

  state_t          state, state_nx;
  logic [4:0][7:0] lam, lam_new, gl;
  logic [3:0][7:0] bb, db;
  logic [3:0][7:0] syn, s_sel, ds;
  logic [7:0]      gam, dlt, dlt_nx;
  logic [2:0]      len, top;
  logic [1:0]      r;
  logic [7:0]      om0, om1a, om1b;
  logic            unc, busy_c;

  logic [2:0][7:0] o_lam;
  logic [1:0][7:0] o_om;
  logic [2:0]      o_deg;
  logic            o_unc, o_key, o_ovr;

  // Discrepancy lanes: lane i pairs Lambda_i with S_(r+1-i); lanes past r see zero.
  always_comb begin
    for (int i = 0; i < 4; i++)
      s_sel[i] = (2'(i) <= r) ? syn[r - 2'(i)] : 8'h00;
  end

  for (genvar i = 0; i < 4; i++) begin : g_disc
    gf256mul u_mul (.a(lam[i]), .b(s_sel[i]), .p(ds[i]));
  end
  assign dlt_nx = ds[0] ^ ds[1] ^ ds[2] ^ ds[3];

  // Lambda update: gamma*Lambda(x) xor delta*x*B(x)
  for (genvar i = 0; i < 5; i++) begin : g_gl
    gf256mul u_mul (.a(gam), .b(lam[i]), .p(gl[i]));
  end
  for (genvar i = 0; i < 4; i++) begin : g_db
    gf256mul u_mul (.a(dlt), .b(bb[i]), .p(db[i]));
  end
  assign lam_new = gl ^ {db, 8'h00};

  gf256mul u_om0  (.a(lam[0]), .b(syn[0]), .p(om0));
  gf256mul u_om1a (.a(lam[0]), .b(syn[1]), .p(om1a));
  gf256mul u_om1b (.a(lam[1]), .b(syn[0]), .p(om1b));

  always_comb begin
    top = 3'd0;
    for (int i = 1; i < 5; i++)
      if (lam[i] != 8'h00) top = 3'(i);
    unc = (len > 3'd2) || (lam[3] != 8'h00) || (lam[4] != 8'h00) || (top != len);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (kes.syndrome_val) begin
`ifdef RS_KES_ZERO_BYPASS_EN
        if ({kes.syndrome1, kes.syndrome2, kes.syndrome3, kes.syndrome4} == 32'h0)
          state_nx = OMEGA;
        else
          state_nx = DISC;
`else
        state_nx = DISC;
`endif
      end
      DISC:    state_nx = UPD;
      UPD:     state_nx = (r == 2'd3) ? OMEGA : DISC;
      OMEGA:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_c = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lam   <= '0;
      bb    <= '0;
      syn   <= '0;
      gam   <= 8'h00;
      dlt   <= 8'h00;
      len   <= 3'd0;
      r     <= 2'd0;
      o_lam <= '0;
      o_om  <= '0;
      o_deg <= 3'd0;
      o_unc <= 1'b0;
      o_key <= 1'b0;
      o_ovr <= 1'b0;
    end else begin
      o_key <= 1'b0;
      o_ovr <= kes.syndrome_val && (state != IDLE);
      case (state)
        IDLE: if (kes.syndrome_val) begin
          syn <= {kes.syndrome4, kes.syndrome3, kes.syndrome2, kes.syndrome1};
          lam <= {32'h0, 8'h01};
          bb  <= {24'h0, 8'h01};
          gam <= 8'h01;
          len <= 3'd0;
          r   <= 2'd0;
        end
        DISC: dlt <= dlt_nx;
        UPD: begin
          lam <= lam_new;
          if (dlt != 8'h00 && {len, 1'b0} <= {2'b00, r}) begin
            bb  <= lam[3:0];
            len <= 3'(r) + 3'd1 - len;
            gam <= dlt;
          end else begin
            bb  <= {bb[2:0], 8'h00};
          end
          r <= r + 2'd1;
        end
        OMEGA: begin
          o_lam <= lam[2:0];
          o_om  <= {om1a ^ om1b, om0};
          o_deg <= len;
          o_unc <= unc;
          o_key <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign kes.busy          = busy_c;
  assign kes.key_val       = o_key;
  assign kes.lambda0       = o_lam[0];
  assign kes.lambda1       = o_lam[1];
  assign kes.lambda2       = o_lam[2];
  assign kes.omega0        = o_om[0];
  assign kes.omega1        = o_om[1];
  assign kes.err_deg       = o_deg;
  assign kes.uncorrectable = o_unc;
  assign kes.overrun       = o_ovr;
endmodule

// File: tb/tb_rs_kes_ibm.sv
// Self-checking bench for rs_kes_ibm: directed cases plus random syndromes vs a log/antilog BM model.
module tb_rs_kes_ibm;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_kes_ibm_if kif();
  rs_kes_ibm dut (.clk(clk), .rst_n(rst_n), .kes(kif));

  int n_vec = 0;
  int n_err = 0;
  int gexp [0:509];
  int glog [0:255];

  logic [7:0] e_l0, e_l1, e_l2, e_o0, e_o1, e_deg;
  logic       e_unc;
  int         e_lat;

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: inversionless BM where delta_r is coefficient r of Lambda(x)*S(x).
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    int sp[4];
    int lm[5], bp[5], nl[5];
    int gm, dl, L, hi;
    sp = '{int'(a), int'(b), int'(c), int'(d)};
    lm = '{1, 0, 0, 0, 0};
    bp = '{1, 0, 0, 0, 0};
    gm = 1; L = 0;
    for (int rr = 0; rr < 4; rr++) begin
      dl = 0;
      for (int i = 0; i <= rr; i++) dl ^= gmul(lm[i], sp[rr - i]);
      for (int i = 0; i < 5; i++) nl[i] = gmul(gm, lm[i]) ^ ((i > 0) ? gmul(dl, bp[i-1]) : 0);
      if (dl != 0 && 2 * L <= rr) begin
        bp = lm; L = rr + 1 - L; gm = dl;
      end else begin
        for (int i = 4; i > 0; i--) bp[i] = bp[i-1];
        bp[0] = 0;
      end
      lm = nl;
    end
    hi = 0;
    for (int i = 0; i < 5; i++) if (lm[i] != 0) hi = i;
    e_l0  = 8'(lm[0]);
    e_l1  = 8'(lm[1]);
    e_l2  = 8'(lm[2]);
    e_o0  = 8'(gmul(lm[0], sp[0]));
    e_o1  = 8'(gmul(lm[0], sp[1]) ^ gmul(lm[1], sp[0]));
    e_deg = 8'(L);
    e_unc = (L > 2) || (lm[3] != 0) || (lm[4] != 0) || (hi != L);
`ifdef RS_KES_ZERO_BYPASS_EN
    e_lat = ({a, b, c, d} == 32'h0) ? 2 : 10;
`else
    e_lat = 10;
`endif
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    kif.syndrome_val = 1'b1;
    kif.syndrome1 = a; kif.syndrome2 = b; kif.syndrome3 = c; kif.syndrome4 = d;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".l0"},  kif.lambda0, e_l0);
    chk({tag, ".l1"},  kif.lambda1, e_l1);
    chk({tag, ".l2"},  kif.lambda2, e_l2);
    chk({tag, ".o0"},  kif.omega0,  e_o0);
    chk({tag, ".o1"},  kif.omega1,  e_o1);
    chk({tag, ".deg"}, 8'(kif.err_deg), e_deg);
    chk({tag, ".unc"}, 8'(kif.uncorrectable), 8'(e_unc));
  endtask

  task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    int cyc;
    bit seen;
    @(negedge clk);
    drive(a, b, c, d);
    model(a, b, c, d);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        kif.syndrome_val = 1'b0;
        chk({tag, ".busy1"}, 8'(kif.busy), 8'd1);
      end
      if (kif.key_val) seen = 1'b1;
    end
    chk({tag, ".lat"}, 8'(cyc), 8'(e_lat));
    chk({tag, ".busyk"}, 8'(kif.busy), 8'd0);
    check_out(tag);
    @(negedge clk);
    chk({tag, ".kvpulse"}, 8'(kif.key_val), 8'd0);
  endtask

  initial begin
    int j, j2, e, e2, cyc;
    bit kv;
    logic [7:0] s [4];

    gexp[0] = 1;
    for (int i = 1; i < 510; i++) begin
      int v;
      v = gexp[i-1] << 1;
      if ((v & 256) != 0) v ^= 'h11d;
      gexp[i] = v;
    end
    glog[0] = 0;
    for (int i = 0; i < 255; i++) glog[gexp[i]] = i;

    rst_n = 1'b0;
    kif.syndrome_val = 1'b0;
    kif.syndrome1 = 8'h00; kif.syndrome2 = 8'h00; kif.syndrome3 = 8'h00; kif.syndrome4 = 8'h00;
    repeat (3) @(negedge clk);
    e_l0 = 0; e_l1 = 0; e_l2 = 0; e_o0 = 0; e_o1 = 0; e_deg = 0; e_unc = 0;
    check_out("rst0");
    chk("rst0.kv",   8'(kif.key_val), 8'd0);
    chk("rst0.busy", 8'(kif.busy),    8'd0);
    chk("rst0.ovr",  8'(kif.overrun), 8'd0);
    rst_n = 1'b1;

    run_vec("zero",  8'h00, 8'h00, 8'h00, 8'h00);
    run_vec("e1p0",  8'h01, 8'h01, 8'h01, 8'h01);
    run_vec("e1p1",  8'h02, 8'h04, 8'h08, 8'h10);
    run_vec("fail",  8'h00, 8'h00, 8'h00, 8'h01);

    // Overrun: dropped strobe at n+4, then a strobe coinciding with key_val.
    @(negedge clk);
    drive(8'h01, 8'h01, 8'h01, 8'h01);
    model(8'h01, 8'h01, 8'h01, 8'h01);
    kv = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) kif.syndrome_val = 1'b0;
      if (c == 4) drive(8'h55, 8'h66, 8'h77, 8'h88);
      if (c == 5) begin
        kif.syndrome_val = 1'b0;
        chk("ovr.pulse", 8'(kif.overrun), 8'd1);
      end
      if (c == 6) chk("ovr.pulse_end", 8'(kif.overrun), 8'd0);
      if (c < 10 && kif.key_val) kv = 1'b1;
    end
    chk("ovr.early_kv", 8'(kv), 8'd0);
    chk("ovr.kv10", 8'(kif.key_val), 8'd1);
    check_out("ovr");
    drive(8'h02, 8'h04, 8'h08, 8'h10);
    model(8'h02, 8'h04, 8'h08, 8'h10);
    cyc = 0; kv = 1'b0;
    while (!kv && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) kif.syndrome_val = 1'b0;
      if (kif.key_val) kv = 1'b1;
    end
    chk("b2b.lat", 8'(cyc), 8'd10);
    check_out("b2b");

    // Reset mid-operation: outputs held from the previous result, then cleared.
    run_vec("pre_rst", 8'h01, 8'h01, 8'h01, 8'h01);
    @(negedge clk);
    drive(8'h02, 8'h04, 8'h08, 8'h10);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) kif.syndrome_val = 1'b0;
      if (c == 3) chk("hold.l0", kif.lambda0, 8'h01);
    end
    rst_n = 1'b0;
    @(negedge clk);
    e_l0 = 0; e_l1 = 0; e_l2 = 0; e_o0 = 0; e_o1 = 0; e_deg = 0; e_unc = 0;
    check_out("midrst");
    chk("midrst.busy", 8'(kif.busy), 8'd0);
    rst_n = 1'b1;
    kv = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (kif.key_val) kv = 1'b1;
    end
    chk("midrst.nokv", 8'(kv), 8'd0);
    run_vec("post_rst", 8'h02, 8'h04, 8'h08, 8'h10);

    // Random single-error syndromes S_k = e * alpha^(j*k)
    for (int t = 0; t < 10; t++) begin
      j = int'($urandom_range(0, 254));
      e = int'($urandom_range(1, 255));
      for (int k = 0; k < 4; k++) s[k] = 8'(gmul(e, gexp[(j * (k + 1)) % 255]));
      run_vec("rnd1", s[0], s[1], s[2], s[3]);
    end
    // Random double-error syndromes
    for (int t = 0; t < 10; t++) begin
      j  = int'($urandom_range(0, 254));
      j2 = (j + int'($urandom_range(1, 253))) % 255;
      e  = int'($urandom_range(1, 255));
      e2 = int'($urandom_range(1, 255));
      for (int k = 0; k < 4; k++)
        s[k] = 8'(gmul(e, gexp[(j * (k + 1)) % 255]) ^ gmul(e2, gexp[(j2 * (k + 1)) % 255]));
      run_vec("rnd2", s[0], s[1], s[2], s[3]);
    end
    // Fully random syndromes (mostly decoder failures)
    for (int t = 0; t < 20; t++) begin
      run_vec("rndx", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
